dualmem_port_master: RTL and testbench

- Initiator-side controller for one port of a 512x64 byte-enabled dual-port block RAM with 1-cycle read latency.
- Accepts valid/ready requests from a client (cache refill, DMA or debug bridge) and drives the RAM port pins (en, we, addr, wdata).
- Captures read data and returns an in-order response stream, with backpressure, through a 2-entry response buffer.
- Every request, read or write, gets exactly one response so clients can count completions.

---
 rtl/dualmem_port_master_if.sv | 30 +++
 rtl/dualmem_port_master.sv | 137 +++++++++++++
 tb/tb_dualmem_port_master.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dualmem_port_master_if.sv
// Client-side request/response bus for dualmem_port_master.
// master = client (issues requests, consumes responses), slave = port controller.
interface dualmem_port_master_if #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 64
);
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [BE_WIDTH-1:0]   req_be;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_write;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_write, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_write, rsp_rdata
  );
endinterface

// File: rtl/dualmem_port_master.sv
// Initiator for one port of a byte-enabled 1-cycle-latency block RAM, with an in-order 2-entry response buffer.
// Optional power-up zero fill of the whole RAM: define DUALMEM_PORT_INIT_ZERO_EN.
module dualmem_port_master #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  dualmem_port_master_if.slave  bus,
  output logic                  mem_en,
  output logic [BE_WIDTH-1:0]   mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t                state_q;
  logic                  infl_q;
  logic                  infl_write_q;
  logic [1:0]            cnt_q;
  logic                  head_write_q;
  logic [DATA_WIDTH-1:0] head_data_q;
  logic                  tail_write_q;
  logic [DATA_WIDTH-1:0] tail_data_q;
`ifdef DUALMEM_PORT_INIT_ZERO_EN
  logic [ADDR_WIDTH-1:0] init_addr_q;
`endif

  logic                  run_c;
  logic                  accept_c;
  logic                  push_c;
  logic                  pop_c;
  logic [1:0]            occ_c;
  logic [DATA_WIDTH-1:0] push_data_c;

  // Credits: a response in flight or buffered holds one; a same-cycle pop returns one.
  assign run_c         = rstn && (state_q == ST_RUN);
  assign occ_c         = cnt_q + {1'b0, infl_q};
  assign bus.rsp_valid = (cnt_q != 2'd0);
  assign bus.rsp_write = head_write_q;
  assign bus.rsp_rdata = head_data_q;
  assign pop_c         = bus.rsp_valid && bus.rsp_ready;
  assign bus.req_ready = run_c && ((occ_c < 2'd2) || pop_c);
  assign accept_c      = bus.req_valid && bus.req_ready;
  assign push_c        = infl_q;
  assign push_data_c   = infl_write_q ? '0 : mem_rdata;
  assign busy          = (state_q == ST_INIT) || (occ_c != 2'd0);

  // RAM port pins: zero fill during init, otherwise straight from the accepted request.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
`ifdef DUALMEM_PORT_INIT_ZERO_EN
    if (rstn && (state_q == ST_INIT)) begin
      mem_en   = 1'b1;
      mem_we   = '1;
      mem_addr = init_addr_q;
    end
`endif
    if (accept_c) begin
      mem_en    = 1'b1;
      mem_we    = bus.req_we ? bus.req_be : '0;
      mem_addr  = bus.req_addr;
      mem_wdata = bus.req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
`ifdef DUALMEM_PORT_INIT_ZERO_EN
      state_q     <= ST_INIT;
      init_addr_q <= '0;
`else
      state_q     <= ST_RUN;
`endif
      infl_q       <= 1'b0;
      infl_write_q <= 1'b0;
      cnt_q        <= 2'd0;
      head_write_q <= 1'b0;
      head_data_q  <= '0;
      tail_write_q <= 1'b0;
      tail_data_q  <= '0;
    end else begin
`ifdef DUALMEM_PORT_INIT_ZERO_EN
      if (state_q == ST_INIT) begin
        init_addr_q <= init_addr_q + ADDR_WIDTH'(1);
        if (init_addr_q == '1) state_q <= ST_RUN;
      end
`endif
      infl_q       <= accept_c;
      infl_write_q <= accept_c && bus.req_we;

      // Response FIFO; the tail is cleared whenever it moves so an empty head reads as zero.
      case ({push_c, pop_c})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            head_write_q <= infl_write_q;
            head_data_q  <= push_data_c;
          end else begin
            tail_write_q <= infl_write_q;
            tail_data_q  <= push_data_c;
          end
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          head_write_q <= tail_write_q;
          head_data_q  <= tail_data_q;
          tail_write_q <= 1'b0;
          tail_data_q  <= '0;
          cnt_q        <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            head_write_q <= infl_write_q;
            head_data_q  <= push_data_c;
          end else begin
            head_write_q <= tail_write_q;
            head_data_q  <= tail_data_q;
            tail_write_q <= infl_write_q;
            tail_data_q  <= push_data_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dualmem_port_master.sv
// Scoreboard bench for dualmem_port_master against a write-first byte-enabled RAM model.
module tb_dualmem_port_master;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 64;
  localparam int unsigned BW = DW / 8;

  typedef struct {
    logic          wr;
    logic [DW-1:0] data;
    int            acc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          mem_en;
  logic [BW-1:0] mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy;

  dualmem_port_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  dualmem_port_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            rsp_cnt = 0;
  int            last_rsp_cyc = -10;
  int            streak = 0;
  bit            check_lat = 1'b0;
  logic [DW-1:0] last_rdata = '0;
  logic [AW-1:0] last_acc_addr = '0;
  logic [DW-1:0] ram  [2**AW];
  logic [DW-1:0] refm [2**AW];
  logic [DW-1:0] tmp;
  exp_t          sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Write-first RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      tmp = ram[mem_addr];
      for (int b = 0; b < BW; b++)
        if (mem_we[b]) tmp[b*8 +: 8] = mem_wdata[b*8 +: 8];
      ram[mem_addr] = tmp;
      mem_rdata <= tmp;
    end
  end

  // Scoreboard: push on accept, pop and compare on response handshake.
  always @(negedge clk) begin
    exp_t e;
    logic [DW-1:0] v;
    if (!rstn) begin
      sb.delete();
    end else begin
      if (bus.rsp_valid && bus.rsp_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL stale_rsp got write=%0b rdata=%h want no response", bus.rsp_write, bus.rsp_rdata);
        end else begin
          e = sb.pop_front();
          if (bus.rsp_write !== e.wr || bus.rsp_rdata !== e.data) begin
            n_err++;
            $display("FAIL rsp_data got write=%0b rdata=%h want write=%0b rdata=%h",
                     bus.rsp_write, bus.rsp_rdata, e.wr, e.data);
          end
          if (check_lat) begin
            n_cmp++;
            if ((cyc + 1 - e.acc) != 2) begin
              n_err++;
              $display("FAIL rsp_latency got %0d want 2", cyc + 1 - e.acc);
            end
          end
        end
        if (!bus.rsp_write) last_rdata = bus.rsp_rdata;
        rsp_cnt++;
        streak = (cyc == last_rsp_cyc + 1) ? streak + 1 : 1;
        last_rsp_cyc = cyc;
      end
      if (bus.req_valid && bus.req_ready) begin
        n_cmp++;
        if (mem_en !== 1'b1 || mem_addr !== bus.req_addr || mem_wdata !== bus.req_wdata ||
            mem_we !== (bus.req_we ? bus.req_be : BW'(0))) begin
          n_err++;
          $display("FAIL issue_pins got en=%0b we=%h addr=%h wdata=%h want en=1 we=%h addr=%h wdata=%h",
                   mem_en, mem_we, mem_addr, mem_wdata, bus.req_we ? bus.req_be : BW'(0),
                   bus.req_addr, bus.req_wdata);
        end
        v = refm[bus.req_addr];
        if (bus.req_we) begin
          for (int b = 0; b < BW; b++)
            if (bus.req_be[b]) v[b*8 +: 8] = bus.req_wdata[b*8 +: 8];
          refm[bus.req_addr] = v;
        end
        e.wr = bus.req_we;
        e.data = bus.req_we ? '0 : v;
        e.acc = cyc + 1;
        sb.push_back(e);
        last_acc_addr = bus.req_addr;
      end
    end
  end

  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    bit acc = 1'b0;
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_be    = be;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = bus.req_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.req_valid = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL issue_timeout got req_ready=0 for %0d cycles want accept", n);
    end
  endtask

  task automatic drain();
    int n = 0;
    bit done = 1'b0;
    while (!done && n < 300) begin
      @(negedge clk);
      done = (sb.size() == 0) && !busy;
      n++;
    end
    @(posedge clk);
    #1;
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout got pending=%0d busy=%0b want 0/0", sb.size(), busy);
    end
  endtask

  task automatic do_reset(input int low_cycles);
    rstn = 1'b0;
    repeat (low_cycles) @(posedge clk);
    #1;
    rstn = 1'b1;
`ifdef DUALMEM_PORT_INIT_ZERO_EN
    begin
      int n = 0;
      bit bad_busy = 1'b0;
      bit seen = 1'b0;
      while (!seen && n < 1000) begin
        @(negedge clk);
        if (bus.req_ready) seen = 1'b1;
        else begin
          if (!busy) bad_busy = 1'b1;
          n++;
        end
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (n != 512 || bad_busy) begin
        n_err++;
        $display("FAIL init_length got %0d stalled cycles busy_drop=%0b want 512 busy_drop=0", n, bad_busy);
      end
      for (int i = 0; i < 2**AW; i++) refm[i] = '0;
    end
`endif
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL rst_req_ready got %0b want 0", bus.req_ready); end
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid got %0b want 0", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_write !== 1'b0) begin n_err++; $display("FAIL rst_rsp_write got %0b want 0", bus.rsp_write); end
    n_cmp++; if (bus.rsp_rdata !== '0) begin n_err++; $display("FAIL rst_rsp_rdata got %h want 0", bus.rsp_rdata); end
    n_cmp++;
    if (mem_en !== 1'b0 || mem_we !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
      n_err++;
      $display("FAIL rst_mem_pins got en=%0b we=%h addr=%h wdata=%h want all 0", mem_en, mem_we, mem_addr, mem_wdata);
    end
`ifdef DUALMEM_PORT_INIT_ZERO_EN
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_busy got %0b want 1", busy); end
    @(posedge clk);
    #1;
    do_reset(1);
`else
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %0b want 0", busy); end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_req_ready got %0b want 1", bus.req_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL post_rst_busy got %0b want 0", busy); end
    @(posedge clk);
    #1;
`endif
  endtask

  task automatic test_write_read();
    int c0;
    check_lat = 1'b1;
    bus.rsp_ready = 1'b1;
    c0 = rsp_cnt;
    issue(1'b1, 9'h005, 64'h1122334455667788, 8'hFF);
    issue(1'b0, 9'h005, 64'h0, 8'h00);
    drain();
    n_cmp++; if (last_rdata !== 64'h1122334455667788) begin n_err++; $display("FAIL wr_rd_data got %h want 1122334455667788", last_rdata); end
    n_cmp++; if (rsp_cnt - c0 != 2) begin n_err++; $display("FAIL wr_rd_count got %0d want 2", rsp_cnt - c0); end
  endtask

  task automatic test_partial_write();
    check_lat = 1'b1;
    bus.rsp_ready = 1'b1;
    issue(1'b1, 9'h010, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
    issue(1'b1, 9'h010, 64'h0, 8'h0F);
    issue(1'b0, 9'h010, 64'h0, 8'h00);
    drain();
    n_cmp++; if (last_rdata !== 64'hFFFFFFFF00000000) begin n_err++; $display("FAIL partial_be got %h want ffffffff00000000", last_rdata); end
    issue(1'b1, 9'h010, 64'h123456789ABCDEF0, 8'h00);
    issue(1'b0, 9'h010, 64'h0, 8'h00);
    drain();
    n_cmp++; if (last_rdata !== 64'hFFFFFFFF00000000) begin n_err++; $display("FAIL zero_be got %h want ffffffff00000000", last_rdata); end
  endtask

  task automatic test_backpressure();
    int c0;
    check_lat = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) issue(1'b1, AW'(9'h020 + i), {32'hA5A50000 + 32'(i), 32'h0BADF00D ^ 32'(i)}, 8'hFF);
    drain();
    check_lat = 1'b0;
    c0 = rsp_cnt;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we = 1'b0;
    bus.req_addr = 9'h020;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL bp_accept0 got %0b want 1", bus.req_ready); end
    @(posedge clk); #1; bus.req_addr = 9'h021;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL bp_accept1 got %0b want 1", bus.req_ready); end
    @(posedge clk); #1; bus.req_addr = 9'h022;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL bp_stall%0d got %0b want 0", k, bus.req_ready); end
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL bp_release got %0b want 1", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    drain();
    n_cmp++; if (rsp_cnt - c0 != 3) begin n_err++; $display("FAIL bp_count got %0d want 3", rsp_cnt - c0); end
    n_cmp++; if (last_rdata !== {32'hA5A50002, 32'h0BADF00F}) begin n_err++; $display("FAIL bp_last got %h want a5a500020badf00f", last_rdata); end
  endtask

  task automatic test_back_to_back();
    int c0;
    int t0;
    check_lat = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) issue(1'b1, AW'(9'h1F0 + i), {16'(i), 48'h5A5A_C3C3_0F0F}, 8'hFF);
    drain();
    c0 = rsp_cnt;
    t0 = cyc;
    for (int i = 0; i < 16; i++) issue(1'b0, AW'(9'h1F0 + i), 64'h0, 8'h00);
    n_cmp++; if (cyc - t0 != 16) begin n_err++; $display("FAIL stream_issue_cycles got %0d want 16", cyc - t0); end
    drain();
    n_cmp++; if (rsp_cnt - c0 != 16) begin n_err++; $display("FAIL stream_count got %0d want 16", rsp_cnt - c0); end
    n_cmp++; if (streak != 16) begin n_err++; $display("FAIL stream_consecutive got %0d want 16", streak); end
    n_cmp++; if (last_acc_addr !== 9'h1FF) begin n_err++; $display("FAIL stream_last_addr got %h want 1ff", last_acc_addr); end
  endtask

  task automatic test_reset_midop();
    int c0;
    check_lat = 1'b0;
    bus.rsp_ready = 1'b0;
    issue(1'b0, 9'h020, 64'h0, 8'h00);
    issue(1'b0, 9'h021, 64'h0, 8'h00);
    do_reset(1);
    @(negedge clk);
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL midrst_rsp_valid got %0b want 0", bus.rsp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %0b want 0", busy); end
    @(posedge clk); #1;
    c0 = rsp_cnt;
    bus.rsp_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    n_cmp++; if (rsp_cnt != c0) begin n_err++; $display("FAIL midrst_stale got %0d responses want 0", rsp_cnt - c0); end
    check_lat = 1'b1;
    issue(1'b1, 9'h040, 64'hDEADBEEFCAFEF00D, 8'hFF);
    issue(1'b0, 9'h040, 64'h0, 8'h00);
    drain();
    n_cmp++; if (last_rdata !== 64'hDEADBEEFCAFEF00D) begin n_err++; $display("FAIL midrst_resume got %h want deadbeefcafef00d", last_rdata); end
  endtask

`ifdef DUALMEM_PORT_INIT_ZERO_EN
  task automatic test_init();
    check_lat = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 2**AW; i++) ram[i] = {$urandom, $urandom};
    do_reset(2);
    issue(1'b0, 9'h1A3, 64'h0, 8'h00);
    drain();
    n_cmp++; if (last_rdata !== '0) begin n_err++; $display("FAIL init_zero got %h want 0", last_rdata); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      ram[i]  = {$urandom, $urandom};
      refm[i] = '0;
    end
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_write_read();
    test_partial_write();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
`ifdef DUALMEM_PORT_INIT_ZERO_EN
    test_init();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
